// File: rtl/ext_mem_bridge_pkg.sv
// ext_mem_bridge_pkg: shared state encoding and wait-counter limits for the SRAM bridge.
package ext_mem_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} memb_state_t;
  localparam int WAIT_W   = 4;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
endpackage

// File: rtl/memb_wait_ctr.sv
// memb_wait_ctr: loadable down-counter that saturates at zero; done marks the final strobe cycle.
module memb_wait_ctr
  import ext_mem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [WAIT_W-1:0] load_val,
  output logic              done
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign done = cnt_q == WAIT_W'(1);
endmodule

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: CPU-to-async-SRAM access sequencer (SETUP / STROBE x WAIT_CYCLES / HOLD).
// Define EXT_MEM_BRIDGE_RDCACHE_EN to build a one-entry write-through read cache.
module ext_mem_bridge
  import ext_mem_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_addr_h,
  input  logic [7:0]  cpu_addr_l,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_stall,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dq_out,
  input  logic [7:0]  sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("ext_mem_bridge: WAIT_CYCLES must be in 1..15");
  end
  memb_state_t state_q, state_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d, hit_data;
  logic        done, hit, hit_q, active;
`ifdef EXT_MEM_BRIDGE_RDCACHE_EN
  logic        valid_q, valid_d, hit_d;
  logic [15:0] tag_q, tag_d;
  logic [7:0]  cdata_q, cdata_d;
  assign hit      = valid_q && cpu_rw && {cpu_addr_h, cpu_addr_l} == tag_q;
  assign hit_data = cdata_q;
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    cdata_d = cdata_q;
    hit_d   = (state_q == IDLE && cpu_req) ? hit : hit_q;
    if (state_q == HOLD && !hit_q) begin
      if (rw_q) {valid_d, tag_d, cdata_d} = {1'b1, addr_q, rdata_q};
      else if (valid_q && tag_q == addr_q) cdata_d = wdata_q;
    end
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? 1'b0 : valid_d;
    hit_q   <= rst ? 1'b0 : hit_d;
    tag_q   <= rst ? '0 : tag_d;
    cdata_q <= rst ? '0 : cdata_d;
  end
`else
  assign hit      = 1'b0;
  assign hit_q    = 1'b0;
  assign hit_data = 8'h00;
`endif
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (cpu_req) begin
        state_d = hit ? HOLD : SETUP;
        rw_d    = cpu_rw;
        addr_d  = {cpu_addr_h, cpu_addr_l};
        wdata_d = cpu_wdata;
        rdata_d = hit ? hit_data : rdata_q;
      end
      SETUP:  state_d = STROBE;
      STROBE: if (done) begin
        state_d = HOLD;
        rdata_d = rw_q ? sram_dq_in : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    rw_q    <= rst ? 1'b0 : rw_d;
    addr_q  <= rst ? '0 : addr_d;
    wdata_q <= rst ? '0 : wdata_d;
    rdata_q <= rst ? '0 : rdata_d;
  end
  memb_wait_ctr u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == SETUP),
    .en       (state_q == STROBE),
    .load_val (WAIT_W'(WAIT_CYCLES)),
    .done     (done)
  );
  // a cache-hit HOLD never touches the SRAM
  assign active      = state_q != IDLE && !hit_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = active && !rw_q;
  assign sram_ce_n   = !active;
  assign sram_oe_n   = !(state_q == STROBE && rw_q);
  assign sram_we_n   = !(state_q == STROBE && !rw_q);
  assign cpu_ready   = state_q == HOLD;
  assign cpu_rdata   = rdata_q;
  assign cpu_stall   = (state_q == IDLE && cpu_req) || state_q == SETUP || state_q == STROBE;
endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb_ext_mem_bridge: randomized self-checking bench with a behavioural SRAM and access-timing model.
module tb_ext_mem_bridge;
  localparam int W = 2;
`ifdef EXT_MEM_BRIDGE_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_rw, cpu_ready, cpu_stall;
  logic [7:0]  cpu_addr_h, cpu_addr_l, cpu_wdata, cpu_rdata;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic        q_req, q_rw, q_ready, q_stall, q_dq_oe, q_ce_n, q_oe_n, q_we_n;
  logic [7:0]  q_addr_h, q_addr_l, q_wdata, q_rdata, q_dq_out, q_dq_in;
  logic [15:0] q_addr;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit          m_valid;
  logic [15:0] m_tag;
  int vecs = 0, errs = 0;

  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq_out;

  ext_mem_bridge #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr_h(cpu_addr_h), .cpu_addr_l(cpu_addr_l), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  ext_mem_bridge #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .cpu_req(q_req), .cpu_rw(q_rw),
    .cpu_addr_h(q_addr_h), .cpu_addr_l(q_addr_l), .cpu_wdata(q_wdata),
    .cpu_rdata(q_rdata), .cpu_ready(q_ready), .cpu_stall(q_stall),
    .sram_addr(q_addr), .sram_dq_out(q_dq_out), .sram_dq_in(q_dq_in),
    .sram_dq_oe(q_dq_oe), .sram_ce_n(q_ce_n), .sram_oe_n(q_oe_n), .sram_we_n(q_we_n)
  );

  // Issue one access; measure latency (cycles after the accept edge), strobe counts and stability.
  task automatic run_access(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                            output int lat, output int oe_cnt, output int we_cnt, output int doe_cnt,
                            output int bad, output int rdy_cnt, output logic [7:0] rd);
    lat = -1; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; bad = 0; rdy_cnt = 0; rd = 8'h00;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; {cpu_addr_h, cpu_addr_l} = a; cpu_wdata = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin
        we_cnt++;
        if (sram_dq_out !== wd) bad++;
      end
      if (sram_dq_oe) doe_cnt++;
      if (sram_addr !== a) bad++;
      if (cpu_ready === 1'b1) begin
        rdy_cnt++;
        lat = c;
        rd = cpu_rdata;
        cpu_req = 1'b0;
        break;
      end
      cpu_req = 1'($urandom); cpu_rw = 1'($urandom);
      {cpu_addr_h, cpu_addr_l} = 16'($urandom); cpu_wdata = 8'($urandom);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    if (cpu_ready !== 1'b0) rdy_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (cpu_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
    vecs++; if (cpu_rdata !== 8'h00) begin errs++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
    vecs++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin errs++; $display("FAIL reset_strobes got %b exp 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    vecs++; if (sram_dq_oe !== 1'b0) begin errs++; $display("FAIL reset_dq_oe got %b exp 0", sram_dq_oe); end
    vecs++; if (sram_addr !== 16'h0000) begin errs++; $display("FAIL reset_addr got %h exp 0000", sram_addr); end
    vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL reset_stall_idle got %b exp 0", cpu_stall); end
    cpu_req = 1'b1; #1;
    vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL idle_req_stall got %b exp 1", cpu_stall); end
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_read_basic();
    int lat, oe, we, doe, bad, rdy;
    logic [7:0] rd;
    mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    run_access(1'b1, 16'h1234, 8'h00, lat, oe, we, doe, bad, rdy, rd);
    vecs++; if (lat !== W + 1) begin errs++; $display("FAIL rd_latency got %0d exp %0d", lat, W + 1); end
    vecs++; if (oe !== W) begin errs++; $display("FAIL rd_oe_cycles got %0d exp %0d", oe, W); end
    vecs++; if (we !== 0) begin errs++; $display("FAIL rd_we_cycles got %0d exp 0", we); end
    vecs++; if (rd !== 8'hA5) begin errs++; $display("FAIL rd_data got %h exp a5", rd); end
    vecs++; if (rdy !== 1) begin errs++; $display("FAIL rd_ready_pulses got %0d exp 1", rdy); end
    vecs++; if (bad !== 0 || doe !== 0) begin errs++; $display("FAIL rd_bus got bad=%0d dq_oe=%0d exp 0/0", bad, doe); end
    m_valid = 1'b1; m_tag = 16'h1234;
  endtask

  task automatic test_write_basic();
    int lat, oe, we, doe, bad, rdy;
    logic [7:0] rd;
    run_access(1'b0, 16'h00FF, 8'h3C, lat, oe, we, doe, bad, rdy, rd);
    ref_mem[16'h00FF] = 8'h3C;
    vecs++; if (lat !== W + 1) begin errs++; $display("FAIL wr_latency got %0d exp %0d", lat, W + 1); end
    vecs++; if (we !== W) begin errs++; $display("FAIL wr_we_cycles got %0d exp %0d", we, W); end
    vecs++; if (oe !== 0) begin errs++; $display("FAIL wr_oe_cycles got %0d exp 0", oe); end
    vecs++; if (doe !== W + 2) begin errs++; $display("FAIL wr_dq_oe_cycles got %0d exp %0d", doe, W + 2); end
    vecs++; if (rdy !== 1 || bad !== 0) begin errs++; $display("FAIL wr_pulse_bus got rdy=%0d bad=%0d exp 1/0", rdy, bad); end
    vecs++; if (mem[16'h00FF] !== 8'h3C) begin errs++; $display("FAIL wr_sram_data got %h exp 3c", mem[16'h00FF]); end
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b1; {cpu_addr_h, cpu_addr_l} = 16'h4321;
    @(negedge clk); cpu_req = 1'b0;
    @(negedge clk);
    vecs++; if (sram_oe_n !== 1'b0) begin errs++; $display("FAIL mid_in_strobe got oe_n=%b exp 0", sram_oe_n); end
    rst = 1'b1;
    @(negedge clk);
    vecs++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin errs++; $display("FAIL mid_strobes got %b exp 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    vecs++; if (cpu_ready !== 1'b0 || cpu_stall !== 1'b0) begin errs++; $display("FAIL mid_ready_stall got %b%b exp 00", cpu_ready, cpu_stall); end
    vecs++; if (cpu_rdata !== 8'h00) begin errs++; $display("FAIL mid_rdata got %h exp 00", cpu_rdata); end
    rst = 1'b0; m_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready) rdy++;
    end
    vecs++; if (rdy !== 0) begin errs++; $display("FAIL mid_no_ready got %0d exp 0", rdy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0] rd2;
    int s, n;
    bit e_ce, e_rdy, e_st;
    a = 16'h7000 | 16'($urandom_range(0, 255));
    s = W + 3;
    n = CACHE ? s : s + W + 1;
    rd2 = 8'h00;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b1; {cpu_addr_h, cpu_addr_l} = a;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      e_ce  = !((c <= W + 1) || (!CACHE && c >= s && c <= n));
      e_rdy = (c == W + 1) || (c == n);
      vecs++; if (sram_ce_n !== e_ce) begin errs++; $display("FAIL b2b_ce_n c=%0d got %b exp %b", c, sram_ce_n, e_ce); end
      vecs++; if (cpu_ready !== e_rdy) begin errs++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, cpu_ready, e_rdy); end
      if (c != W + 2) begin
        e_st = (c <= W) || (c >= s && c < n);
        vecs++; if (cpu_stall !== e_st) begin errs++; $display("FAIL b2b_stall c=%0d got %b exp %b", c, cpu_stall, e_st); end
      end
      if (c == n) begin
        rd2 = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    vecs++; if (rd2 !== ref_mem[a]) begin errs++; $display("FAIL b2b_rdata got %h exp %h", rd2, ref_mem[a]); end
    m_valid = 1'b1; m_tag = a;
    @(negedge clk);
  endtask

`ifdef EXT_MEM_BRIDGE_RDCACHE_EN
  task automatic test_cache();
    int lat, oe, we, doe, bad, rdy;
    logic [7:0] rd;
    mem[16'h0200] = 8'h11; ref_mem[16'h0200] = 8'h11;
    run_access(1'b1, 16'h0200, 8'h00, lat, oe, we, doe, bad, rdy, rd);
    vecs++; if (rd !== 8'h11) begin errs++; $display("FAIL cache_fill_data got %h exp 11", rd); end
    run_access(1'b0, 16'h0200, 8'h22, lat, oe, we, doe, bad, rdy, rd);
    ref_mem[16'h0200] = 8'h22;
    run_access(1'b1, 16'h0200, 8'h00, lat, oe, we, doe, bad, rdy, rd);
    vecs++; if (lat !== 0) begin errs++; $display("FAIL cache_hit_latency got %0d exp 0", lat); end
    vecs++; if (rd !== 8'h22) begin errs++; $display("FAIL cache_hit_data got %h exp 22", rd); end
    vecs++; if (oe !== 0 || doe !== 0) begin errs++; $display("FAIL cache_hit_strobes got oe=%0d dq_oe=%0d exp 0/0", oe, doe); end
    m_valid = 1'b1; m_tag = 16'h0200;
  endtask
`endif

  task automatic test_random();
    int lat, oe, we, doe, bad, rdy;
    logic [7:0] rd, wd;
    logic [15:0] a;
    logic rw;
    bit hit;
    for (int i = 0; i < 16; i++) begin
      rw = 1'($urandom);
      a  = {8'h02, 8'($urandom_range(0, 3))};
      wd = 8'($urandom);
      hit = CACHE && m_valid && rw && a == m_tag;
      run_access(rw, a, wd, lat, oe, we, doe, bad, rdy, rd);
      vecs++; if (lat !== (hit ? 0 : W + 1)) begin errs++; $display("FAIL rnd_latency i=%0d got %0d exp %0d", i, lat, hit ? 0 : W + 1); end
      vecs++; if (oe !== ((rw && !hit) ? W : 0) || we !== (rw ? 0 : W)) begin errs++; $display("FAIL rnd_strobes i=%0d got oe=%0d we=%0d", i, oe, we); end
      vecs++; if (rdy !== 1 || bad !== 0) begin errs++; $display("FAIL rnd_pulse_bus i=%0d got rdy=%0d bad=%0d exp 1/0", i, rdy, bad); end
      if (rw) begin
        vecs++; if (rd !== ref_mem[a]) begin errs++; $display("FAIL rnd_rdata i=%0d got %h exp %h", i, rd, ref_mem[a]); end
        m_valid = 1'b1; m_tag = a;
      end else begin
        ref_mem[a] = wd;
        vecs++; if (mem[a] !== wd) begin errs++; $display("FAIL rnd_sram_write i=%0d got %h exp %h", i, mem[a], wd); end
      end
    end
  endtask

  task automatic test_wait15();
    int lat = -1, oe = 0;
    logic [7:0] rd = 8'h00;
    @(negedge clk);
    q_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      q_req = 1'b0;
      if (!q_oe_n) oe++;
      if (q_ready) begin
        lat = c; rd = q_rdata;
        break;
      end
    end
    vecs++; if (lat !== 16) begin errs++; $display("FAIL w15_latency got %0d exp 16", lat); end
    vecs++; if (oe !== 15) begin errs++; $display("FAIL w15_oe_cycles got %0d exp 15", oe); end
    vecs++; if (rd !== 8'h5A) begin errs++; $display("FAIL w15_rdata got %h exp 5a", rd); end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr_h = 8'h00; cpu_addr_l = 8'h00; cpu_wdata = 8'h00;
    q_req = 1'b0; q_rw = 1'b1; q_addr_h = 8'h5A; q_addr_l = 8'hA5; q_wdata = 8'h00; q_dq_in = 8'h5A;
    m_valid = 1'b0; m_tag = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_read_basic();
    test_write_basic();
    test_reset_mid();
    test_back_to_back();
`ifdef EXT_MEM_BRIDGE_RDCACHE_EN
    test_cache();
`endif
    test_random();
    test_wait15();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
